// File: rtl/dmem_responder_if.sv
// Request/response bus between the pipeline memory stage and dmem_responder.
// The master drives requests; the slave (responder) returns the single-cycle
// response, the ready handshake and the stall to the pipeline.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_error;
    logic        stall;

    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_error, stall
    );

    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_error, stall
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder for the RISC-V load/store port.
// One request at a time over valid/ready; byte/half/word/doubleword access to a
// little-endian byte array; single-cycle response LATENCY edges after acceptance.
// Optional build macro: DMEM_MISALIGN_TRAP_EN -- when defined, misaligned
// accesses return an error instead of being aligned down.
module dmem_responder #(
    parameter int unsigned DEPTH_BYTES = 512,
    parameter int unsigned LATENCY     = 2
) (
    input  logic           clk,
    input  logic           reset,
    dmem_responder_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH_BYTES);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;

    logic            r_ready;
    logic            r_resp_valid;
    logic [63:0]     r_resp_rdata;
    logic            r_resp_error;
    logic [63:0]     r_hold_rdata;
    logic            r_hold_error;

    logic [7:0]      r_mem [DEPTH_BYTES];

    logic            w_accept;
    logic [3:0]      w_nbytes;
    logic [2:0]      w_mask;
    logic [64:0]     w_end;
    logic            w_in_range;
    logic            w_error;
    logic [AW-1:0]   w_base;
    logic [63:0]     w_load_data;
    logic [63:0]     w_rdata;

    assign w_accept = bus.req_valid && r_ready;

    // Decode size, range and alignment of the request currently on the bus
    always_comb begin
        w_nbytes   = 4'(4'd1 << bus.req_size);
        w_mask     = 3'(w_nbytes - 4'd1);
        w_end      = {1'b0, bus.req_addr} + 65'(w_nbytes);
        w_in_range = (w_end <= 65'(DEPTH_BYTES));
        w_base     = bus.req_addr[AW-1:0] & ~AW'(w_mask);
`ifdef DMEM_MISALIGN_TRAP_EN
        w_error    = !w_in_range || (|(bus.req_addr[2:0] & w_mask));
`else
        w_error    = !w_in_range;
`endif
    end

    // Gather load bytes little-endian, zero-extended above the access size
    always_comb begin
        w_load_data = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (4'(i) < w_nbytes) begin
                w_load_data[8*i +: 8] = r_mem[w_base + AW'(i)];
            end
        end
        w_rdata = (bus.req_write || w_error) ? 64'd0 : w_load_data;
    end

    // Storage: cleared on reset, stores commit at the acceptance edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned j = 0; j < DEPTH_BYTES; j++) begin
                r_mem[j] <= 8'd0;
            end
        end else if (w_accept && bus.req_write && !w_error) begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (4'(i) < w_nbytes) begin
                    r_mem[w_base + AW'(i)] <= bus.req_wdata[8*i +: 8];
                end
            end
        end
    end

    // Next-state and counter: IDLE/RESP accept, WAIT counts LATENCY-1 cycles
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            S_IDLE, S_RESP: begin
                if (w_accept) begin
                    if (LATENCY == 1) begin
                        w_next     = S_RESP;
                        w_cnt_next = '0;
                    end else begin
                        w_next     = S_WAIT;
                        w_cnt_next = CW'(LATENCY - 1);
                    end
                end else begin
                    w_next     = S_IDLE;
                    w_cnt_next = '0;
                end
            end
            S_WAIT: begin
                if (r_cnt <= CW'(1)) begin
                    w_next     = S_RESP;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt - CW'(1);
                end
            end
            default: begin
                w_next     = S_IDLE;
                w_cnt_next = '0;
            end
        endcase
    end

    // State register with registered ready/valid decodes of the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_ready      <= 1'b1;
            r_resp_valid <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_cnt        <= w_cnt_next;
            r_ready      <= (w_next != S_WAIT);
            r_resp_valid <= (w_next == S_RESP);
        end
    end

    // Response payload: captured at acceptance, presented only in the RESP cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold_rdata <= '0;
            r_hold_error <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_error <= 1'b0;
        end else begin
            if (w_accept) begin
                r_hold_rdata <= w_rdata;
                r_hold_error <= w_error;
            end
            if (w_next == S_RESP) begin
                r_resp_rdata <= w_accept ? w_rdata : r_hold_rdata;
                r_resp_error <= w_accept ? w_error : r_hold_error;
            end else begin
                r_resp_rdata <= '0;
                r_resp_error <= 1'b0;
            end
        end
    end

    assign bus.req_ready  = r_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_error = r_resp_error;
    assign bus.stall      = bus.req_valid && !r_ready;

endmodule
